// File: rtl/ram_generic_nr1w_pkg.sv
// Shared sizing helpers for the nR1W generic RAM and its basic banks.
package ram_generic_nr1w_pkg;

  function automatic int byte_width(input int data_w, input int n_masks);
    return data_w / n_masks;
  endfunction

  function automatic int bank_count(input int memd, input int basic_model);
    return memd / basic_model;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_bank_1rw1r.sv
// One basic bank: masked write port shared with NLANES read lanes, plus one independent read port.
module ram_bank_1rw1r
  import ram_generic_nr1w_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int NLANES     = 2,
  parameter int OFF_W      = 8
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [NUM_WMASKS-1:0]              wmask,
  input  logic [OFF_W-1:0]                   waddr,
  input  logic [DATA_WIDTH-1:0]              din,
  input  logic [NLANES-1:0]                  re,
  input  logic [NLANES-1:0][OFF_W-1:0]       raddr,
  input  logic                               re1,
  input  logic [OFF_W-1:0]                   raddr1,
  output logic [NLANES-1:0][DATA_WIDTH-1:0]  rdata,
  output logic [DATA_WIDTH-1:0]              rdata1
);

  localparam int BW = byte_width(DATA_WIDTH, NUM_WMASKS);

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Array access on the falling edge; NBA ordering gives port 1 the pre-write word.
  always_ff @(negedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_WMASKS; i++)
        if (wmask[i]) mem[waddr][i*BW +: BW] <= din[i*BW +: BW];
    end
    for (int p = 0; p < NLANES; p++)
      if (re[p]) rdata[p] <= mem[raddr[p]];
    if (re1) rdata1 <= mem[raddr1];
  end

endmodule

// File: rtl/ram_generic_nr1w.sv
// Byte-maskable nR1W SRAM model: inputs captured on rising clk, array/outputs updated on falling clk.
module ram_generic_nr1w
  import ram_generic_nr1w_pkg::*;
#(
  parameter int NUM_WMASKS  = 4,
  parameter int MEMD        = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int nRPORTS     = 2,
  parameter int nWPORTS     = 1,
  parameter int IZERO       = 1,
  parameter     IFILE       = "",
  parameter int BASIC_MODEL = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int DELAY       = 3
) (
`ifdef USE_POWER_PINS
  inout  wire                              vccd1,
  inout  wire                              vssd1,
`endif
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             csb,
  input  logic                             web,
  input  logic [NUM_WMASKS-1:0]            wmask,
  input  logic [ADDR_WIDTH*nRPORTS-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [DATA_WIDTH*nRPORTS-1:0]    dout,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH-1:0]            dout1
);

  localparam int NBANKS = bank_count(MEMD, BASIC_MODEL);
  localparam int OFF_W  = idx_width(BASIC_MODEL);
  localparam int SEL_W  = idx_width(NBANKS);

  if (nWPORTS != 1) begin : g_bad_wports
    $error("ram_generic_nr1w: only a single write port is supported");
  end
  if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_mask
    $error("ram_generic_nr1w: DATA_WIDTH must divide evenly into NUM_WMASKS bytes");
  end
  if (MEMD % BASIC_MODEL != 0) begin : g_bad_bank
    $error("ram_generic_nr1w: MEMD must be a multiple of BASIC_MODEL");
  end
  if ((1 << ADDR_WIDTH) < MEMD) begin : g_bad_aw
    $error("ram_generic_nr1w: ADDR_WIDTH too narrow for MEMD");
  end
  if (IZERO == 0 && IFILE != "") begin : g_bad_init
    $error("ram_generic_nr1w: file preload is not supported by this model");
  end
  if (DELAY < 0) begin : g_bad_delay
    $error("ram_generic_nr1w: DELAY must be non-negative");
  end

  typedef struct packed {
    logic                                rst;
    logic                                csb;
    logic                                web;
    logic [NUM_WMASKS-1:0]               wmask;
    logic [nRPORTS-1:0][ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]               din;
    logic                                csb1;
    logic [ADDR_WIDTH-1:0]               addr1;
  } req_t;

  req_t req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      req_q.rst  <= 1'b1;
      req_q.csb  <= 1'b1;
      req_q.web  <= 1'b1;
      req_q.csb1 <= 1'b1;
    end else begin
      req_q.rst   <= 1'b0;
      req_q.csb   <= csb;
      req_q.web   <= web;
      req_q.wmask <= wmask;
      req_q.addr  <= addr;
      req_q.din   <= din;
      req_q.csb1  <= csb1;
      req_q.addr1 <= addr1;
    end
  end

  logic                           rd_op, wr_op, p1_op;
  logic [nRPORTS-1:0]             lane_ok;
  logic [nRPORTS-1:0][SEL_W-1:0]  lane_sel;
  logic [nRPORTS-1:0][OFF_W-1:0]  lane_off;
  logic                           p1_ok;
  logic [SEL_W-1:0]               p1_sel;
  logic [OFF_W-1:0]               p1_off;

  assign rd_op = !req_q.csb && req_q.web;
  assign wr_op = !req_q.csb && !req_q.web;
  assign p1_op = !req_q.csb1;

  // Out-of-range addresses enable no bank; their lanes read back as zero.
  always_comb begin
    lane_ok  = '0;
    lane_sel = '0;
    lane_off = '0;
    for (int p = 0; p < nRPORTS; p++) begin
      lane_ok[p]  = int'(req_q.addr[p]) < MEMD;
      lane_sel[p] = SEL_W'(int'(req_q.addr[p]) / BASIC_MODEL);
      lane_off[p] = OFF_W'(int'(req_q.addr[p]) % BASIC_MODEL);
    end
    p1_ok  = int'(req_q.addr1) < MEMD;
    p1_sel = SEL_W'(int'(req_q.addr1) / BASIC_MODEL);
    p1_off = OFF_W'(int'(req_q.addr1) % BASIC_MODEL);
  end

  logic [NBANKS-1:0][nRPORTS-1:0][DATA_WIDTH-1:0] bank_rd;
  logic [NBANKS-1:0][DATA_WIDTH-1:0]              bank_rd1;

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    logic [nRPORTS-1:0] re;
    logic               we, re1;

    always_comb begin
      re = '0;
      for (int p = 0; p < nRPORTS; p++)
        re[p] = rd_op && lane_ok[p] && (int'(lane_sel[p]) == g);
    end
    assign we  = wr_op && lane_ok[0] && (int'(lane_sel[0]) == g);
    assign re1 = p1_op && p1_ok && (int'(p1_sel) == g);

    ram_bank_1rw1r #(
      .DEPTH      (BASIC_MODEL),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WMASKS (NUM_WMASKS),
      .NLANES     (nRPORTS),
      .OFF_W      (OFF_W)
    ) u_bank (
      .clk    (clk),
      .we     (we),
      .wmask  (req_q.wmask),
      .waddr  (lane_off[0]),
      .din    (req_q.din),
      .re     (re),
      .raddr  (lane_off),
      .re1    (re1),
      .raddr1 (p1_off),
      .rdata  (bank_rd[g]),
      .rdata1 (bank_rd1[g])
    );
  end

  // Per-lane record of which bank last served a read; banks hold their own data between reads.
  logic [nRPORTS-1:0][SEL_W-1:0] sel_q;
  logic [nRPORTS-1:0]            zero_q;
  logic [SEL_W-1:0]              sel1_q;
  logic                          zero1_q;

  always_ff @(negedge clk) begin
    if (req_q.rst) begin
      zero_q  <= '1;
      zero1_q <= 1'b1;
    end else begin
      if (rd_op) begin
        sel_q  <= lane_sel;
        zero_q <= ~lane_ok;
      end
      if (p1_op) begin
        sel1_q  <= p1_sel;
        zero1_q <= !p1_ok;
      end
    end
  end

  logic [nRPORTS-1:0][DATA_WIDTH-1:0] dout_l;

  always_comb begin
    dout_l = '0;
    for (int p = 0; p < nRPORTS; p++)
      dout_l[p] = zero_q[p] ? '0 : bank_rd[sel_q[p]][p];
  end

  assign dout  = dout_l;
  assign dout1 = zero1_q ? '0 : bank_rd1[sel1_q];

endmodule

// File: tb/tb_ram_generic_nr1w.sv
// Directed and randomized checks of ram_generic_nr1w against a byte-masked reference array.
module tb_ram_generic_nr1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb, web, csb1;
  logic [3:0]  wmask;
  logic [15:0] addr;
  logic [31:0] din;
  logic [7:0]  addr1;
  logic [63:0] dout;
  logic [31:0] dout1;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] model [256];
  logic [63:0] exp_dout;
  logic [31:0] exp_dout1;

  always #5 clk = ~clk;

  ram_generic_nr1w dut (
    .clk   (clk),
    .rst   (rst),
    .csb   (csb),
    .web   (web),
    .wmask (wmask),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .csb1  (csb1),
    .addr1 (addr1),
    .dout1 (dout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full cycle: drive, capture on rise, execute on fall, then advance the reference.
  task automatic step(input logic r, input logic c, input logic w, input logic [3:0] m,
                      input logic [7:0] a1, input logic [7:0] a0, input logic [31:0] d,
                      input logic c1, input logic [7:0] aa1);
    rst = r; csb = c; web = w; wmask = m; addr = {a1, a0}; din = d; csb1 = c1; addr1 = aa1;
    @(posedge clk);
    @(negedge clk);
    #1;
    if (r) begin
      exp_dout  = '0;
      exp_dout1 = '0;
    end else begin
      if (!c1) exp_dout1 = model[aa1];
      if (!c && w) exp_dout = {model[a1], model[a0]};
      if (!c && !w)
        for (int i = 0; i < 4; i++)
          if (m[i]) model[a0][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    exp_dout  = '0;
    exp_dout1 = '0;

    step(1, 1, 1, 4'h0, 8'h00, 8'h00, 32'h0, 1, 8'h00);
    check("reset_dout", dout, 64'h0);
    check("reset_dout1", {32'h0, dout1}, 64'h0);

    step(0, 0, 1, 4'h0, 8'hFF, 8'h00, 32'h0, 1, 8'h00);
    check("zero_init", dout, 64'h0);

    step(0, 0, 0, 4'hF, 8'h00, 8'h10, 32'hDEADBEEF, 1, 8'h00);
    check("write_holds_dout", dout, 64'h0);
    step(0, 0, 1, 4'h0, 8'h10, 8'h10, 32'h0, 1, 8'h00);
    check("full_write_rd", dout, 64'hDEADBEEF_DEADBEEF);

    step(0, 0, 0, 4'b0101, 8'h00, 8'h10, 32'h11223344, 1, 8'h00);
    step(0, 0, 1, 4'h0, 8'h10, 8'h10, 32'h0, 1, 8'h00);
    check("byte_mask", dout, 64'hDE22BE44_DE22BE44);

    step(0, 0, 1, 4'h0, 8'h00, 8'h10, 32'h0, 1, 8'h00);
    check("lanes_differ", dout, 64'h00000000_DE22BE44);
    step(0, 0, 0, 4'hF, 8'h00, 8'h20, 32'hCAFEF00D, 1, 8'h00);
    check("hold_on_write", dout, 64'h00000000_DE22BE44);
    step(0, 0, 1, 4'h0, 8'h10, 8'h20, 32'h0, 1, 8'h00);
    check("two_addr_rd", dout, 64'hDE22BE44_CAFEF00D);

    step(0, 0, 0, 4'hF, 8'h00, 8'h10, 32'hA5A5A5A5, 0, 8'h10);
    check("p1_old_word", {32'h0, dout1}, {32'h0, 32'hDE22BE44});
    step(0, 1, 1, 4'h0, 8'h00, 8'h00, 32'h0, 0, 8'h10);
    check("p1_new_word", {32'h0, dout1}, {32'h0, 32'hA5A5A5A5});
    check("hold_on_csb", dout, 64'hDE22BE44_CAFEF00D);
    step(0, 1, 1, 4'h0, 8'h00, 8'h00, 32'h0, 1, 8'h20);
    check("p1_hold", {32'h0, dout1}, {32'h0, 32'hA5A5A5A5});

    step(0, 0, 0, 4'h0, 8'h00, 8'h20, 32'h12345678, 1, 8'h00);
    step(0, 0, 1, 4'h0, 8'h10, 8'h20, 32'h0, 1, 8'h00);
    check("zero_mask_write", dout, 64'hA5A5A5A5_CAFEF00D);

    for (int n = 0; n < 1000; n++) begin
      logic       r, c, w, c1;
      logic [7:0] a0, a1, aa1;
      r   = (n == 500);
      c   = ($urandom_range(0, 3) == 0);
      w   = $urandom_range(0, 1) != 0;
      c1  = $urandom_range(0, 2) == 0;
      a0  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      a1  = ($urandom_range(0, 3) == 0) ? a0 : 8'($urandom_range(0, 15));
      aa1 = ($urandom_range(0, 1) != 0) ? a0 : 8'($urandom_range(0, 15));
      step(r, c, w, 4'($urandom), a1, a0, $urandom, c1, aa1);
      check(r ? "rand_rst_dout" : "rand_dout", dout, exp_dout);
      check(r ? "rand_rst_dout1" : "rand_dout1", {32'h0, dout1}, {32'h0, exp_dout1});
    end

    step(0, 0, 1, 4'h0, 8'h20, 8'h10, 32'h0, 1, 8'h00);
    check("final_read", dout, {model[8'h20], model[8'h10]});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
